// File: rtl/femto8_mem_arbiter_if.sv
// femto8 arbiter bus bundle: two master ports plus the RAM port.
// slave = arbiter side, master = masters/RAM side.
interface femto8_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;

  logic [DW-1:0] rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/femto8_mem_arbiter.sv
// femto8 two-master RAM arbiter: round-robin with master-1 locked bursts.
// Define ARB_FIXED_PRIO_EN to make master 0 always win a simultaneous request.
module femto8_mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  femto8_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1,
    LOCK1
  } state_t;

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CONE = CW'(1);

  state_t        state, state_nx;
  logic          ptr, ptr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          g0, g1;
  logic          hold, prio1;

  logic          en_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          v1, id1, v2, id2;

  // grant selection and state/pointer/burst-count update
  always_comb begin
    g0       = 1'b0;
    g1       = 1'b0;
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    prio1    = 1'b0;
    hold     = bus.m1_req && bus.m1_lock;

    if (state == LOCK1 && hold) begin
      if (cnt < CMAX) begin
        g1 = 1'b1;
      end else if (bus.m0_req) begin
        g0 = 1'b1;
      end else begin
        g1 = 1'b1;
      end
    end else begin
`ifdef ARB_FIXED_PRIO_EN
      prio1 = 1'b0;
`else
      prio1 = (state == LOCK1) ? 1'b0 : ptr;
`endif
      if (bus.m0_req && bus.m1_req) begin
        g0 = !prio1;
        g1 = prio1;
      end else begin
        g0 = bus.m0_req;
        g1 = bus.m1_req;
      end
    end

    if (!reset_n) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end

    unique case (1'b1)
      g0: begin
        state_nx = OWN0;
        ptr_nx   = 1'b1;
        cnt_nx   = '0;
      end
      g1: begin
        ptr_nx = 1'b0;
        if (bus.m1_lock) begin
          state_nx = LOCK1;
          if (state == LOCK1 && cnt < CMAX) begin
            cnt_nx = cnt + CONE;
          end else begin
            cnt_nx = CONE;
          end
        end else begin
          state_nx = OWN1;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        if (state == LOCK1) begin
          ptr_nx = 1'b0;
        end
      end
    endcase
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end

  // register the winning beat onto the RAM port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (g0 || g1) begin
      en_q    <= 1'b1;
      we_q    <= g1 ? bus.m1_we : bus.m0_we;
      addr_q  <= g1 ? bus.m1_addr : bus.m0_addr;
      wdata_q <= g1 ? bus.m1_wdata : bus.m0_wdata;
    end else begin
      en_q <= 1'b0;
      we_q <= 1'b0;
    end
  end

  // two-stage read tag pipe: stage 1 = RAM cycle, stage 2 = data cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1  <= 1'b0;
      id1 <= 1'b0;
      v2  <= 1'b0;
      id2 <= 1'b0;
    end else begin
      v1  <= (g0 && !bus.m0_we) || (g1 && !bus.m1_we);
      id1 <= g1;
      v2  <= v1;
      id2 <= id1;
    end
  end

  assign bus.m0_gnt    = g0;
  assign bus.m1_gnt    = g1;
  assign bus.m0_rvalid = v2 && !id2;
  assign bus.m1_rvalid = v2 && id2;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_femto8_mem_arbiter.sv
// Directed bench for femto8_mem_arbiter with a small RAM model.
// Unwritten RAM locations read back as addr ^ 8'h5A.
module tb_femto8_mem_arbiter;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;

  logic [7:0]   wr_mem [256];
  logic [255:0] wr_valid = '0;

  femto8_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  femto8_mem_arbiter #(
    .AW(8),
    .DW(8),
    .BURST_MAX(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        wr_mem[bus.mem_addr]   <= bus.mem_wdata;
        wr_valid[bus.mem_addr] <= 1'b1;
      end else if (wr_valid[bus.mem_addr]) begin
        bus.mem_rdata <= wr_mem[bus.mem_addr];
      end else begin
        bus.mem_rdata <= bus.mem_addr ^ 8'h5A;
      end
    end
  end

  task automatic test_reset;
    logic seen;
    reset_n = 1'b0;
    bus.m0_req = 1'b1;
    bus.m0_addr = 8'h10;
    @(negedge clk);
    total++;
    if (bus.m0_gnt !== 1'b0 || bus.mem_en !== 1'b0 ||
        bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold gnt=%b en=%b rv=%b%b want 0000",
               bus.m0_gnt, bus.mem_en, bus.m0_rvalid, bus.m1_rvalid);
    end
    bus.m0_req = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.m1_req = 1'b1;
    bus.m1_lock = 1'b1;
    bus.m1_we = 1'b0;
    bus.m1_addr = 8'h30;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (bus.mem_en !== 1'b1 || bus.m1_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL burst_pre_reset en=%b rv1=%b want 1 1",
               bus.mem_en, bus.m1_rvalid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.m1_gnt !== 1'b0 || bus.mem_en !== 1'b0 ||
        bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 ||
        bus.mem_wdata !== 8'h00 || bus.m0_rvalid !== 1'b0 ||
        bus.m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async g1=%b en=%b we=%b a=%h d=%h rv=%b%b want all 0",
               bus.m1_gnt, bus.mem_en, bus.mem_we, bus.mem_addr,
               bus.mem_wdata, bus.m0_rvalid, bus.m1_rvalid);
    end
    bus.m1_req = 1'b0;
    bus.m1_lock = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.m0_rvalid || bus.m1_rvalid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL stale_rvalid seen=%b want 0", seen);
    end
    @(posedge clk);
    #1;
    bus.m0_req = 1'b1;
    bus.m0_we = 1'b0;
    bus.m0_addr = 8'h10;
    @(negedge clk);
    total++;
    if (bus.m0_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rd10_gnt got=%b want 1", bus.m0_gnt);
    end
    @(posedge clk);
    #1 bus.m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 8'h10 || bus.m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd10_mem en=%b we=%b a=%h rv=%b want 1 0 10 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.m0_rvalid);
    end
    @(negedge clk);
    total++;
    if (bus.m0_rvalid !== 1'b1 || bus.rdata !== 8'h4A) begin
      bad++;
      $display("FAIL rd10_data rv=%b rdata=%h want 1 4a",
               bus.m0_rvalid, bus.rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read;
    bus.m1_req = 1'b1;
    bus.m1_we = 1'b1;
    bus.m1_addr = 8'h20;
    bus.m1_wdata = 8'hA5;
    @(negedge clk);
    total++;
    if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
      bad++;
      $display("FAIL wr_gnt g0=%b g1=%b want 0 1", bus.m0_gnt, bus.m1_gnt);
    end
    @(posedge clk);
    #1 bus.m1_we = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 8'h20 || bus.mem_wdata !== 8'hA5 ||
        bus.m1_gnt !== 1'b1) begin
      bad++;
      $display("FAIL wr_mem en=%b we=%b a=%h d=%h g1=%b want 1 1 20 a5 1",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               bus.m1_gnt);
    end
    @(posedge clk);
    #1 bus.m1_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.m1_rvalid !== 1'b0 || bus.m0_rvalid !== 1'b0 ||
        bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL wr_no_rvalid rv=%b%b en=%b we=%b want 00 1 0",
               bus.m0_rvalid, bus.m1_rvalid, bus.mem_en, bus.mem_we);
    end
    @(negedge clk);
    total++;
    if (bus.m1_rvalid !== 1'b1 || bus.rdata !== 8'hA5 ||
        bus.m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd20_data rv1=%b rv0=%b rdata=%h want 1 0 a5",
               bus.m1_rvalid, bus.m0_rvalid, bus.rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alternate;
    logic       e1, r1;
    logic [7:0] ed;
    bus.m0_req = 1'b1;
    bus.m0_we = 1'b0;
    bus.m0_addr = 8'h01;
    bus.m1_req = 1'b1;
    bus.m1_we = 1'b0;
    bus.m1_lock = 1'b0;
    bus.m1_addr = 8'h02;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        e1 = !FIXED && (i % 2 == 1);
        total++;
        if (bus.m0_gnt !== !e1 || bus.m1_gnt !== e1) begin
          bad++;
          $display("FAIL alt_gnt[%0d] g0=%b g1=%b want %b %b",
                   i, bus.m0_gnt, bus.m1_gnt, !e1, e1);
        end
      end
      if (i >= 2) begin
        r1 = !FIXED && ((i - 2) % 2 == 1);
        ed = r1 ? 8'h58 : 8'h5B;
        total++;
        if (bus.m0_rvalid !== !r1 || bus.m1_rvalid !== r1 ||
            bus.rdata !== ed) begin
          bad++;
          $display("FAIL alt_rv[%0d] rv0=%b rv1=%b rdata=%h want %b %b %h",
                   i, bus.m0_rvalid, bus.m1_rvalid, bus.rdata, !r1, r1, ed);
        end
      end
      @(posedge clk);
      #1;
      if (i == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
    end
  endtask

  task automatic test_lock;
    logic [5:0] seq1;
    int         waits;
    int         m0_start;
    logic       got0;
    seq1 = 6'b101111;
    m0_start = FIXED ? 1 : 0;
    waits = 0;
    bus.m0_req = 1'b1;
    bus.m0_we = 1'b1;
    bus.m0_addr = 8'h40;
    bus.m0_wdata = 8'h11;
    @(posedge clk);
    #1;
    bus.m0_we = 1'b0;
    bus.m0_addr = 8'h04;
    bus.m0_req = (m0_start == 0);
    bus.m1_req = 1'b1;
    bus.m1_lock = 1'b1;
    bus.m1_we = 1'b0;
    bus.m1_addr = 8'h03;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got0 = bus.m0_gnt;
      if (bus.m0_req && !bus.m0_gnt) waits++;
      total++;
      if (bus.m1_gnt !== seq1[i] || bus.m0_gnt !== !seq1[i]) begin
        bad++;
        $display("FAIL lock_gnt[%0d] g0=%b g1=%b want %b %b",
                 i, bus.m0_gnt, bus.m1_gnt, !seq1[i], seq1[i]);
      end
      @(posedge clk);
      #1;
      if (got0) bus.m0_req = 1'b0;
      if (i == 0 && m0_start == 1) bus.m0_req = 1'b1;
    end
    bus.m1_req = 1'b0;
    bus.m1_lock = 1'b0;
    total++;
    if (waits != 4 - m0_start) begin
      bad++;
      $display("FAIL lock_m0_wait got=%0d want %0d", waits, 4 - m0_start);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_burst_restart;
    bus.m1_req = 1'b1;
    bus.m1_lock = 1'b1;
    bus.m1_we = 1'b1;
    bus.m1_addr = 8'h70;
    bus.m1_wdata = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
        bad++;
        $display("FAIL restart_gnt[%0d] g0=%b g1=%b want 0 1",
                 i, bus.m0_gnt, bus.m1_gnt);
      end
      @(posedge clk);
      #1;
    end
    bus.m1_req = 1'b0;
    bus.m1_lock = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    logic [7:0] ea;
    bus.m0_req = 1'b1;
    bus.m0_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.m0_addr = 8'h50 + 8'(i);
      bus.m0_wdata = 8'(i);
      @(negedge clk);
      total++;
      if (bus.m0_gnt !== 1'b1) begin
        bad++;
        $display("FAIL single_gnt[%0d] got=%b want 1", i, bus.m0_gnt);
      end
      if (i > 0) begin
        ea = 8'h50 + 8'(i - 1);
        total++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== ea) begin
          bad++;
          $display("FAIL single_mem[%0d] en=%b a=%h want 1 %h",
                   i, bus.mem_en, bus.mem_addr, ea);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b1;
    bus.m1_we = 1'b0;
    bus.m1_lock = 1'b0;
    bus.m1_addr = 8'h05;
    @(negedge clk);
    total++;
    if (bus.m1_gnt !== 1'b1 || bus.mem_en !== 1'b1 ||
        bus.mem_addr !== 8'h52) begin
      bad++;
      $display("FAIL single_m1 g1=%b en=%b a=%h want 1 1 52",
               bus.m1_gnt, bus.mem_en, bus.mem_addr);
    end
    @(posedge clk);
    #1 bus.m1_req = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_both_prio;
    logic e0;
    bus.m0_req = 1'b1;
    bus.m0_we = 1'b1;
    bus.m0_addr = 8'h60;
    bus.m1_req = 1'b1;
    bus.m1_we = 1'b1;
    bus.m1_lock = 1'b0;
    bus.m1_addr = 8'h61;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e0 = FIXED || (i % 2 == 0);
      total++;
      if (bus.m0_gnt !== e0 || bus.m1_gnt !== !e0) begin
        bad++;
        $display("FAIL prio_gnt[%0d] g0=%b g1=%b want %b %b",
                 i, bus.m0_gnt, bus.m1_gnt, e0, !e0);
      end
      @(posedge clk);
      #1;
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.m0_req = 1'b0;
    bus.m0_we = 1'b0;
    bus.m0_addr = 8'h00;
    bus.m0_wdata = 8'h00;
    bus.m1_req = 1'b0;
    bus.m1_we = 1'b0;
    bus.m1_lock = 1'b0;
    bus.m1_addr = 8'h00;
    bus.m1_wdata = 8'h00;
    test_reset();
    test_write_read();
    test_alternate();
    test_lock();
    test_burst_restart();
    test_single();
    test_both_prio();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
